// File: rtl/math_round_ctrl.sv
// Round controller for the math challenge game. Generates addition problems
// from an LFSR, reloads and watches the countdown timer, scores each answer
// and ends the game after ROUNDS problems.
module math_round_ctrl #(
  parameter int unsigned ROUNDS    = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       submit_i,
  input  logic [4:0] answer_i,
  input  logic [3:0] time_left_i,
  output logic       timer_reload_n_o,
  output logic [3:0] op_a_o,
  output logic [3:0] op_b_o,
  output logic [3:0] score_o,
  output logic [3:0] round_num_o,
  output logic       correct_o,
  output logic       wrong_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] RoundsC = 4'(ROUNDS);

  typedef enum logic [2:0] {IDLE, LOAD, ASK, CHECK, DONE} stateT;

  stateT      state_q, state_d;
  logic [3:0] tlMeta_q, tlSync_q;
  logic       startPrev_q, submitPrev_q;
  logic [7:0] lfsr_q;
  logic [3:0] opA_q, opA_d, opB_q, opB_d;
  logic [3:0] score_q, score_d, roundNum_q, roundNum_d;
  logic [4:0] answer_q, answer_d;
  logic       timeout_q, timeout_d;
  logic       correct_q, correct_d, wrong_q, wrong_d;
  logic       reload_q, reload_d, busy_q, busy_d, done_q, done_d;

  logic       startRise, submitRise, answerGood, lastRound;
  logic [3:0] roundInc;

  assign startRise  = start_i & ~startPrev_q;
  assign submitRise = submit_i & ~submitPrev_q;
  assign answerGood = ~timeout_q && (answer_q == ({1'b0, opA_q} + {1'b0, opB_q}));
  assign roundInc   = roundNum_q + 4'd1;
  assign lastRound  = (roundInc == RoundsC);

  // Synchronize the timer value, keep edge-detect history and run the LFSR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlMeta_q     <= 4'd0;
      tlSync_q     <= 4'd0;
      startPrev_q  <= 1'b1;
      submitPrev_q <= 1'b1;
      lfsr_q       <= LFSR_SEED;
    end else begin
      tlMeta_q     <= time_left_i;
      tlSync_q     <= tlMeta_q;
      startPrev_q  <= start_i;
      submitPrev_q <= submit_i;
      lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: LOAD waits for the reloaded timer, ASK ends on submit or expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startRise) state_d = LOAD;
      LOAD:    if (tlSync_q == 4'd10) state_d = ASK;
      ASK:     if (submitRise || (tlSync_q == 4'd0)) state_d = CHECK;
      CHECK:   state_d = lastRound ? DONE : LOAD;
      DONE:    if (startRise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; submit beats expiry in ASK
  always_comb begin
    opA_d      = opA_q;
    opB_d      = opB_q;
    score_d    = score_q;
    roundNum_d = roundNum_q;
    answer_d   = answer_q;
    timeout_d  = timeout_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    if (((state_q == IDLE) || (state_q == DONE)) && startRise) begin
      score_d    = 4'd0;
      roundNum_d = 4'd0;
    end
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      opA_d = lfsr_q[7:4];
      opB_d = lfsr_q[3:0];
    end
    if (state_q == ASK) begin
      if (submitRise) begin
        answer_d  = answer_i;
        timeout_d = 1'b0;
      end else if (tlSync_q == 4'd0) begin
        timeout_d = 1'b1;
      end
    end
    if (state_q == CHECK) begin
      roundNum_d = roundInc;
      correct_d  = answerGood;
      wrong_d    = ~answerGood;
      if (answerGood) score_d = score_q + 4'd1;
    end
    reload_d = (state_d != LOAD);
    busy_d   = (state_d == LOAD) || (state_d == ASK) || (state_d == CHECK);
    done_d   = (state_d == DONE);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opA_q      <= 4'd0;
      opB_q      <= 4'd0;
      score_q    <= 4'd0;
      roundNum_q <= 4'd0;
      answer_q   <= 5'd0;
      timeout_q  <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      reload_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      score_q    <= score_d;
      roundNum_q <= roundNum_d;
      answer_q   <= answer_d;
      timeout_q  <= timeout_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      reload_q   <= reload_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign timer_reload_n_o = reload_q;
  assign op_a_o           = opA_q;
  assign op_b_o           = opB_q;
  assign score_o          = score_q;
  assign round_num_o      = roundNum_q;
  assign correct_o        = correct_q;
  assign wrong_o          = wrong_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_math_round_ctrl.sv
// Bench for math_round_ctrl: plays whole games with randomized answers and
// round kinds against a score/round/LFSR model of the game rules.
module tb_math_round_ctrl;

  localparam int          Rounds = 8;
  localparam logic [7:0]  Seed   = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b1;
  logic       submit_i = 1'b0;
  logic [4:0] answer_i = 5'd0;
  logic [3:0] time_left_i = 4'd7;
  logic       timer_reload_n_o;
  logic [3:0] op_a_o, op_b_o, score_o, round_num_o;
  logic       correct_o, wrong_o, busy_o, done_o;

  int total = 0;
  int bad = 0;
  logic [7:0] mdlLfsr = Seed;
  logic [7:0] lastLfsr = Seed;
  int expScore = 0;
  int expRound = 0;
  int expOpA = 0;
  int expOpB = 0;

  math_round_ctrl #(.ROUNDS(Rounds), .LFSR_SEED(Seed)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .submit_i(submit_i),
    .answer_i(answer_i), .time_left_i(time_left_i),
    .timer_reload_n_o(timer_reload_n_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .score_o(score_o), .round_num_o(round_num_o), .correct_o(correct_o),
    .wrong_o(wrong_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // One step of x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic sub, input logic [4:0] ans,
                               input logic [3:0] tl);
    start_i     = s;
    submit_i    = sub;
    answer_i    = ans;
    time_left_i = tl;
  endtask

  // Advance one clock; the model remembers the LFSR value the DUT saw at the edge
  task automatic tick();
    @(posedge clk);
    lastLfsr = mdlLfsr;
    if (reset) mdlLfsr = lfsrStep(mdlLfsr);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".reload"}, timer_reload_n_o, 1);
    checkOutput({tag, ".opA"}, op_a_o, 0);
    checkOutput({tag, ".opB"}, op_b_o, 0);
    checkOutput({tag, ".score"}, score_o, 0);
    checkOutput({tag, ".round"}, round_num_o, 0);
    checkOutput({tag, ".correct"}, correct_o, 0);
    checkOutput({tag, ".wrong"}, wrong_o, 0);
    checkOutput({tag, ".busy"}, busy_o, 0);
    checkOutput({tag, ".done"}, done_o, 0);
  endtask

  task automatic startGame(input string tag);
    start_i = 1'b1;
    tick();
    start_i  = 1'b0;
    expScore = 0;
    expRound = 0;
    expOpA   = int'(lastLfsr[7:4]);
    expOpB   = int'(lastLfsr[3:0]);
    checkOutput({tag, ".reload"}, timer_reload_n_o, 0);
    checkOutput({tag, ".busy"}, busy_o, 1);
    checkOutput({tag, ".done"}, done_o, 0);
    checkOutput({tag, ".score"}, score_o, 0);
    checkOutput({tag, ".round"}, round_num_o, 0);
    checkOutput({tag, ".opA"}, op_a_o, expOpA);
    checkOutput({tag, ".opB"}, op_b_o, expOpB);
  endtask

  // Timer reports 10 after reload; ASK follows two sync edges later
  task automatic reachAsk(input bit poke);
    time_left_i = 4'd10;
    tick();
    tick();
    checkOutput("load.reloadHeld", timer_reload_n_o, 0);
    tick();
    checkOutput("ask.reload", timer_reload_n_o, 1);
    checkOutput("ask.busy", busy_o, 1);
    time_left_i = 4'd7;
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      if (poke) start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checkOutput("ask.startIgnored", round_num_o, expRound);
    end
  endtask

  // kind: 0 correct submit, 1 wrong submit, 2 timeout, 3 submit as timer hits 0
  task automatic playRound(input int kind, input bit randWrong, input bit poke);
    int sum;
    logic [4:0] ans;
    bit good;
    reachAsk(poke);
    sum = expOpA + expOpB;
    if (randWrong) begin
      ans = 5'($urandom_range(0, 31));
      if (int'(ans) == sum) ans = ans + 5'd1;
    end else begin
      ans = 5'(sum + 1);
    end
    good = 1'b0;
    case (kind)
      0: begin
        applyStimulus(1'b0, 1'b1, 5'(sum), 4'd7); tick(); submit_i = 1'b0; good = 1'b1;
      end
      1: begin
        applyStimulus(1'b0, 1'b1, ans, 4'd7); tick(); submit_i = 1'b0;
      end
      2: begin
        applyStimulus(1'b0, 1'b0, 5'(sum), 4'd0); tick(); tick(); tick();
      end
      default: begin
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0); tick(); tick();
        applyStimulus(1'b0, 1'b1, 5'(sum), 4'd0); tick(); submit_i = 1'b0; good = 1'b1;
      end
    endcase
    checkOutput("check.noPulseYet", int'(correct_o) + int'(wrong_o), 0);
    checkOutput("check.scoreHeld", score_o, expScore);
    time_left_i = 4'd7;
    tick();
    expRound++;
    if (good) expScore++;
    checkOutput("result.correct", correct_o, int'(good));
    checkOutput("result.wrong", wrong_o, int'(!good));
    checkOutput("result.score", score_o, expScore);
    checkOutput("result.round", round_num_o, expRound);
    if (expRound == Rounds) begin
      checkOutput("done.done", done_o, 1);
      checkOutput("done.busy", busy_o, 0);
      checkOutput("done.reload", timer_reload_n_o, 1);
    end else begin
      expOpA = int'(lastLfsr[7:4]);
      expOpB = int'(lastLfsr[3:0]);
      checkOutput("next.reload", timer_reload_n_o, 0);
      checkOutput("next.busy", busy_o, 1);
      checkOutput("next.opA", op_a_o, expOpA);
      checkOutput("next.opB", op_b_o, expOpB);
    end
    tick();
    checkOutput("pulse.oneCycle", int'(correct_o) + int'(wrong_o), 0);
  endtask

  task automatic checkDoneHold();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("done.holdScore", score_o, expScore);
      checkOutput("done.holdRound", round_num_o, expRound);
      checkOutput("done.holdDone", done_o, 1);
    end
  endtask

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    tick();
    tick();
    checkResetOutputs("inReset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkResetOutputs("idleStartHeld");
    start_i = 1'b0;
    tick();
    checkResetOutputs("idleStartLow");

    // Game 1: each round kind once, then random kinds
    startGame("game1");
    playRound(0, 1'b0, 1'b0);
    playRound(1, 1'b0, 1'b0);
    playRound(2, 1'b0, 1'b0);
    playRound(3, 1'b0, 1'b0);
    for (int r = 4; r < Rounds; r++) playRound(int'($urandom_range(0, 3)), 1'b1, 1'b1);
    checkDoneHold();

    // Game 2: all answers correct, restarted from DONE
    startGame("game2");
    for (int r = 0; r < Rounds; r++) playRound(($urandom_range(0, 1) == 0) ? 0 : 3, 1'b1, 1'b1);
    checkOutput("full.score", score_o, Rounds);
    checkOutput("full.round", round_num_o, Rounds);
    checkDoneHold();

    // Game 3: reset while waiting for an answer
    startGame("game3");
    playRound(0, 1'b0, 1'b0);
    playRound(0, 1'b0, 1'b0);
    reachAsk(1'b0);
    #2 reset = 1'b0;
    mdlLfsr = Seed;
    #1;
    checkResetOutputs("resetMidAsk");
    tick();
    tick();
    checkResetOutputs("resetHeld");
    reset = 1'b1;
    tick();
    tick();
    checkResetOutputs("afterReset");
    startGame("game4");
    playRound(0, 1'b0, 1'b0);
    playRound(int'($urandom_range(1, 2)), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
